instruction_fetch_unit: RTL

Sequences instruction fetches from the byte-addressed, little-endian instruction memory. It holds the program counter, issues one word request at a time over a req/ack handshake, and presents each fetched instruction with its PC to the decode stage over a valid/ready handshake. It sits between the core's control path (redirects from branch/jump resolution) and the instruction memory. It flags misaligned or out-of-range fetch targets instead of issuing them.

---
 rtl/instruction_fetch_unit_pkg.sv | 23 ++
 rtl/instruction_fetch_unit_if.sv | 30 +++
 rtl/instruction_fetch_unit_fetch_out_reg.sv | 35 +++
 rtl/instruction_fetch_unit.sv | 109 ++++++++++
 4 files changed

// File: rtl/instruction_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: FSM encodings,
// instruction size, reset PC default and the fetch-target legality check.
package instruction_fetch_unit_pkg;

    // FSM encodings (also visible on the fsm_state debug port)
    localparam logic [1:0] ST_FETCH = 2'd0;  // request outstanding or about to issue
    localparam logic [1:0] ST_FULL  = 2'd1;  // output holds an unaccepted word, no request
    localparam logic [1:0] ST_FAULT = 2'd2;  // fetch target illegal, fetching halted

    localparam int          INSN_BYTES       = 4;
    localparam logic [63:0] RESET_PC_DEFAULT = 64'd0;

    // A word fetch is legal when it is word aligned and the whole word lies
    // inside the memory. The compare is done on the full address value, so an
    // address whose +4 would wrap past zero is still rejected.
    function automatic logic fetch_legal(input logic [63:0] addr,
                                         input logic [63:0] imem_bytes);
        fetch_legal = (addr[1:0] == 2'b00)
                   && (imem_bytes >= 64'(INSN_BYTES))
                   && (addr <= imem_bytes - 64'(INSN_BYTES));
    endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Bus bundle of the fetch unit: instruction-memory request side and the
// decode-facing output side.
//
// Handshakes: imem_req/imem_ack - a request is held with a stable imem_addr
// until the cycle imem_ack is high (ack may arrive in the same cycle as req);
// that cycle completes the transfer and imem_rdata is valid in it.
// inst_valid/inst_ready - a word transfers in every cycle where both are high;
// while inst_valid is high and inst_ready low, instruction/inst_pc hold.
interface instruction_fetch_unit_if #(parameter int ADDR_W = 64);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic [31:0]       imem_rdata;
    logic              inst_valid;
    logic              inst_ready;
    logic [31:0]       instruction;
    logic [ADDR_W-1:0] inst_pc;

    // Fetch unit side
    modport master (
        output imem_req, imem_addr, inst_valid, instruction, inst_pc,
        input  imem_ack, imem_rdata, inst_ready
    );

    // Memory / decode side
    modport slave (
        input  imem_req, imem_addr, inst_valid, instruction, inst_pc,
        output imem_ack, imem_rdata, inst_ready
    );
endinterface

// File: rtl/instruction_fetch_unit_fetch_out_reg.sv
// Output holding register toward decode: loads a fetched word, holds it
// until accepted, and can be flushed (held word discarded) by a redirect.
module fetch_out_reg #(
    parameter int ADDR_W = 64
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              flush,
    input  logic              load,
    input  logic [31:0]       load_data,
    input  logic [ADDR_W-1:0] load_pc,
    input  logic              ready,
    output logic              valid,
    output logic [31:0]       data,
    output logic [ADDR_W-1:0] pc
);

    // Flush wins over load; an accepted word empties the register unless refilled
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid <= 1'b0;
            data  <= 32'd0;
            pc    <= '0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
            pc    <= load_pc;
        end else if (ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the PC, issues one word request at a time to
// instruction memory, and hands fetched words with their PC to decode.
// Illegal fetch targets halt fetching with a sticky fault until a redirect.
// ADDR_W is expected to be at most 64 (legality check works on 64 bits).
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter int                ADDR_W     = 64,
    parameter logic [ADDR_W-1:0] RESET_PC   = ADDR_W'(RESET_PC_DEFAULT),
    parameter int unsigned       IMEM_BYTES = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              fault,
    output logic [1:0]        fsm_state,
    instruction_fetch_unit_if.master bus
);

    logic [1:0]        state;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_inc;
    logic              squash;       // outstanding request whose data must be dropped
    logic [ADDR_W-1:0] squash_addr;  // address of that request, held until its ack
    logic              out_valid;
    logic              out_free;
    logic              capture;
    logic [31:0]       out_data;
    logic [ADDR_W-1:0] out_pc;

    assign pc_inc   = pc + ADDR_W'(INSN_BYTES);
    assign out_free = !out_valid || bus.inst_ready;

    // Request is issued only when the output can take the word (empty or
    // draining this cycle), so an ack never meets a stalled output. A squashed
    // request stays up until its ack regardless of state. imem_addr depends
    // only on registered state.
    assign bus.imem_req  = reset_n && (squash || ((state == ST_FETCH) && out_free));
    assign bus.imem_addr = squash ? squash_addr : pc;

    assign capture = !redirect_valid && !squash && (state == ST_FETCH)
                  && bus.imem_req && bus.imem_ack;

    assign fault      = (state == ST_FAULT);
    assign fsm_state  = state;

    assign bus.inst_valid  = out_valid;
    assign bus.instruction = out_data;
    assign bus.inst_pc     = out_pc;

    // PC / FSM update: redirect first, then completion of a squashed request,
    // then normal fetch sequencing
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_FETCH;
            pc          <= RESET_PC;
            squash      <= 1'b0;
            squash_addr <= '0;
        end else if (redirect_valid) begin
            pc          <= redirect_pc;
            state       <= fetch_legal(64'(redirect_pc), 64'(IMEM_BYTES)) ? ST_FETCH : ST_FAULT;
            squash      <= bus.imem_req && !bus.imem_ack;
            squash_addr <= bus.imem_addr;
        end else if (squash) begin
            if (bus.imem_ack) begin
                squash <= 1'b0;
            end
        end else begin
            case (state)
                ST_FETCH: begin
                    if (capture) begin
                        pc <= pc_inc;
                        if (!fetch_legal(64'(pc_inc), 64'(IMEM_BYTES))) begin
                            state <= ST_FAULT;
                        end
                    end else if (!out_free) begin
                        state <= ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (bus.inst_ready) begin
                        state <= ST_FETCH;
                    end
                end
                ST_FAULT: begin
                    state <= ST_FAULT;
                end
                default: begin
                    state <= ST_FAULT;
                end
            endcase
        end
    end

    fetch_out_reg #(.ADDR_W(ADDR_W)) u_out_reg (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (redirect_valid),
        .load      (capture),
        .load_data (bus.imem_rdata),
        .load_pc   (pc),
        .ready     (bus.inst_ready),
        .valid     (out_valid),
        .data      (out_data),
        .pc        (out_pc)
    );

endmodule
